switch_debounce: RTL and testbench



---
 rtl/switch_pkg.sv | 19 +
 rtl/switch_debounce_ch.sv | 58 +++++
 rtl/switch_debounce.sv | 64 ++++++
 tb/tb_switch_debounce.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : switch_pkg
//  Description : Shared constants and helpers for the switch debounce slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package switch_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
    localparam int SIM_DEBOUNCE_CYCLES     = 4;
    localparam int GLITCH_CNT_W            = 8;

    // Counter wide enough to hold DEBOUNCE_CYCLES-1 with one bit of headroom.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage : switch_pkg
`default_nettype wire

// File: rtl/switch_debounce_ch.sv
`default_nettype none
// ============================================================================
//  Module      : switch_debounce_ch
//  Description : One switch channel: 2-flop synchronizer, consecutive-sample
//                debounce counter, registered stable level, reject strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_debounce_ch
    import switch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sw,
    output logic o_stable,
    output logic o_settling,
    output logic o_reject
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_settling;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_sw;
            r_sync2 <= r_sync1;
            // Any sample agreeing with the current level restarts qualification.
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign w_settling = (r_cnt != '0);
    assign o_stable   = r_stable;
    assign o_settling = w_settling;
    // A candidate change is being thrown away on this edge.
    assign o_reject   = w_settling && (r_sync2 == r_stable);

endmodule : switch_debounce_ch
`default_nettype wire

// File: rtl/switch_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : switch_debounce
//  Description : N_SW independent switch debouncers. Optional saturating
//                rejected-bounce counter enabled by SWITCH_DEBOUNCE_GLITCH_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_debounce
    import switch_pkg::*;
#(
    parameter int N_SW            = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_SW-1:0]         sw_in,
    output logic [N_SW-1:0]         sw_stable,
    output logic [N_SW-1:0]         sw_settling
`ifdef SWITCH_DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [GLITCH_CNT_W-1:0] glitch_cnt
`endif
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

    logic [N_SW-1:0] w_reject;

    generate
        for (genvar gi = 0; gi < N_SW; gi++) begin : g_ch
            switch_debounce_ch #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_ch (
                .clk        (clk),
                .rst        (reset),
                .i_sw       (sw_in[gi]),
                .o_stable   (sw_stable[gi]),
                .o_settling (sw_settling[gi]),
                .o_reject   (w_reject[gi])
            );
        end
    endgenerate

`ifdef SWITCH_DEBOUNCE_GLITCH_CNT_EN
    logic [GLITCH_CNT_W-1:0] r_glitch_cnt;

    // Simultaneous rejects on several channels count as one event.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_glitch_cnt <= '0;
        end else if ((|w_reject) && (r_glitch_cnt != '1)) begin
            r_glitch_cnt <= r_glitch_cnt + GLITCH_CNT_W'(1);
        end
    end

    assign glitch_cnt = r_glitch_cnt;
`else
    logic w_unused_reject;
    assign w_unused_reject = |w_reject;
`endif

endmodule : switch_debounce
`default_nettype wire

// File: tb/tb_switch_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_switch_debounce
//  Description : Directed self-checking bench for switch_debounce with a
//                history-based reference model (N_SW=2, DEBOUNCE_CYCLES=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_debounce;
    import switch_pkg::*;

    localparam int N     = 2;
    localparam int DC    = SIM_DEBOUNCE_CYCLES;
    localparam int HMAX  = 8192;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] sw_in = '1;
    logic [N-1:0] sw_stable;
    logic [N-1:0] sw_settling;
`ifdef SWITCH_DEBOUNCE_GLITCH_CNT_EN
    logic [GLITCH_CNT_W-1:0] glitch_cnt;
`endif

    int checks = 0;
    int errors = 0;

    switch_debounce #(
        .N_SW            (N),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sw_in       (sw_in),
        .sw_stable   (sw_stable),
        .sw_settling (sw_settling)
`ifdef SWITCH_DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_cnt  (glitch_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-edge history of what the second sync stage holds.
    // A level is accepted when the last DC post-reset samples all disagree with it.
    logic [N-1:0] eff_h [HMAX];
    logic [N-1:0] s2_h  [HMAX];
    logic         rst_h [HMAX];
    logic [N-1:0] m_stable = '0;
    logic [N-1:0] m_settle = '0;
    int           m_glitch = 0;
    bit           m_valid  = 1'b0;
    int           e = 0;

    always @(posedge clk) begin
        bit any_rej;
        e = e + 1;
        if (e >= HMAX) begin
            $display("FAIL model_history_overflow actual=%0d required<%0d", e, HMAX);
            $fatal(1, "history overflow");
        end
        rst_h[e] = reset;
        eff_h[e] = reset ? '0 : sw_in;
        if (reset) begin
            m_stable = '0;
            m_settle = '0;
            m_glitch = 0;
            s2_h[e]  = '0;
        end else begin
            any_rej = 1'b0;
            for (int ch = 0; ch < N; ch++) begin
                logic s2;
                bit   flip;
                s2 = (e < 3 || rst_h[e-1]) ? 1'b0 : eff_h[e-2][ch];
                s2_h[e][ch] = s2;
                if (m_settle[ch] && s2 == m_stable[ch]) any_rej = 1'b1;
                flip = 1'b1;
                for (int j = 0; j < DC; j++) begin
                    if (e - j < 1) flip = 1'b0;
                    else if (rst_h[e-j] || s2_h[e-j][ch] == m_stable[ch]) flip = 1'b0;
                end
                m_settle[ch] = !flip && (s2 != m_stable[ch]);
                if (flip) m_stable[ch] = ~m_stable[ch];
            end
            if (any_rej && m_glitch < 255) m_glitch = m_glitch + 1;
        end
        m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_stable", 32'(sw_stable), 32'(m_stable));
            check("model_settling", 32'(sw_settling), 32'(m_settle));
`ifdef SWITCH_DEBOUNCE_GLITCH_CNT_EN
            check("model_glitch", 32'(glitch_cnt), 32'(m_glitch));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   rises;
        logic prev;

        // Reset with both switches held high, then re-qualification.
        reset = 1'b1;
        sw_in = 2'b11;
        repeat (2) tick();
        check("rst_stable", 32'(sw_stable), 32'h0);
        check("rst_settling", 32'(sw_settling), 32'h0);
        reset = 1'b0;
        repeat (5) tick();
        check("requal_edge5", 32'(sw_stable), 32'h0);
        tick();
        check("requal_edge6", 32'(sw_stable), 32'h3);

        // Clean 0->1 on channel 0.
        sw_in = 2'b00;
        repeat (10) tick();
        check("both_low", 32'(sw_stable), 32'h0);
        sw_in = 2'b01;
        tick();
        tick();
        check("settle_k1", 32'(sw_settling[0]), 32'h0);
        tick();
        check("settle_k2", 32'(sw_settling[0]), 32'h1);
        repeat (2) tick();
        check("stable_k4", 32'(sw_stable[0]), 32'h0);
        tick();
        check("stable_k5", 32'(sw_stable[0]), 32'h1);
        check("settle_k5", 32'(sw_settling[0]), 32'h0);

        // Three-cycle pulse on channel 1 is rejected.
        sw_in = 2'b11;
        repeat (3) tick();
        sw_in = 2'b01;
        repeat (10) tick();
        check("pulse_stable1", 32'(sw_stable[1]), 32'h0);
        check("pulse_settle1", 32'(sw_settling[1]), 32'h0);
`ifdef SWITCH_DEBOUNCE_GLITCH_CNT_EN
        check("pulse_glitch", 32'(glitch_cnt), 32'h1);
`endif

        // Chatter on channel 0, then a held high level.
        sw_in = 2'b00;
        repeat (10) tick();
        rises = 0;
        prev  = sw_stable[0];
        for (int c = 0; c < 40; c++) begin
            sw_in[0] = ((c / 2) % 2 == 0);
            tick();
            if (!prev && sw_stable[0]) rises++;
            prev = sw_stable[0];
        end
        sw_in[0] = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (!prev && sw_stable[0]) rises++;
            prev = sw_stable[0];
            if (c == 5) check("chatter_hold5", 32'(sw_stable[0]), 32'h0);
            if (c == 6) check("chatter_hold6", 32'(sw_stable[0]), 32'h1);
        end
        check("chatter_rises", 32'(rises), 32'h1);

        // Reset in the middle of qualifying channel 1.
        sw_in = 2'b11;
        repeat (4) tick();
        check("mid_settling", 32'(sw_settling), 32'h2);
        reset = 1'b1;
        tick();
        check("midrst_stable", 32'(sw_stable), 32'h0);
        check("midrst_settling", 32'(sw_settling), 32'h0);
        reset = 1'b0;
        repeat (5) tick();
        check("midrst_edge5", 32'(sw_stable), 32'h0);
        tick();
        check("midrst_edge6", 32'(sw_stable), 32'h3);

        // 300 single-sample dropouts on channel 1, each rejected.
        for (int b = 0; b < 300; b++) begin
            sw_in = 2'b01;
            tick();
            sw_in = 2'b11;
            repeat (3) tick();
        end
        repeat (5) tick();
        check("bounce_stable", 32'(sw_stable), 32'h3);
`ifdef SWITCH_DEBOUNCE_GLITCH_CNT_EN
        check("glitch_sat", 32'(glitch_cnt), 32'hFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_switch_debounce
`default_nettype wire
